// File: rtl/ethercat_pkg.sv
// Shared command codes, FMMU type bits, FSM states and WKC helper for the FMMU block.
package ethercat_pkg;

  localparam logic [7:0] CMD_LRD = 8'h0A;
  localparam logic [7:0] CMD_LWR = 8'h0B;
  localparam logic [7:0] CMD_LRW = 8'h0C;

  localparam int FMMU_TYPE_RD = 0;
  localparam int FMMU_TYPE_WR = 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MAP,
    ST_PASS,
    ST_DONE
  } fmmu_state_t;

  function automatic logic is_logical(input logic [7:0] cmd);
    return (cmd == CMD_LRD) || (cmd == CMD_LWR) || (cmd == CMD_LRW);
  endfunction

  // LRW counts a read hit as 1 and a write hit as 2.
  function automatic logic [1:0] wkc_calc(input logic [7:0] cmd, input logic rd_hit,
                                          input logic wr_hit);
    case (cmd)
      CMD_LRD: return {1'b0, rd_hit};
      CMD_LWR: return {1'b0, wr_hit};
      CMD_LRW: return {wr_hit, rd_hit};
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/ethercat_fmmu_match.sv
// One FMMU channel: logical window hit test and logical-to-physical translation.
// Purely combinational; no flow control.
module ethercat_fmmu_match
  import ethercat_pkg::*;
#(
  parameter int PHY_AW = 16,
  parameter int LEN_W  = 16
) (
  input  logic [31:0]       laddr,
  input  logic [31:0]       log_start,
  input  logic [LEN_W-1:0]  len,
  input  logic [PHY_AW-1:0] phy_start,
  input  logic [1:0]        cfg_type,
  input  logic              enable,
  output logic              hit,
  output logic              rd_en,
  output logic              wr_en,
  output logic [PHY_AW-1:0] phy_addr
);

  // 33-bit end so a window touching the top of the logical space never wraps.
  logic [32:0] win_end;

  assign win_end  = {1'b0, log_start} + 33'(len);
  assign hit      = enable && (len != '0) && (laddr >= log_start) && ({1'b0, laddr} < win_end);
  assign rd_en    = cfg_type[FMMU_TYPE_RD];
  assign wr_en    = cfg_type[FMMU_TYPE_WR];
  assign phy_addr = phy_start + PHY_AW'(laddr - log_start);

endmodule

// File: rtl/ethercat_fmmu_multi.sv
// Multi-channel byte-streaming FMMU: maps logical datagram bytes onto the physical bus.
// Fixed 2-cycle byte latency, no bubbles, no backpressure (stream must be accepted every cycle).
module ethercat_fmmu_multi
  import ethercat_pkg::*;
#(
  parameter int N_FMMU = 3,
  parameter int PHY_AW = 16,
  parameter int LEN_W  = 16
) (
  input  logic                     rxc,
  input  logic                     rst_n,
  input  logic [N_FMMU*32-1:0]     cfg_log_start,
  input  logic [N_FMMU*LEN_W-1:0]  cfg_len,
  input  logic [N_FMMU*PHY_AW-1:0] cfg_phy_start,
  input  logic [N_FMMU*2-1:0]      cfg_type,
  input  logic [N_FMMU-1:0]        cfg_enable,
  input  logic                     sub_start,
  input  logic [7:0]               sub_command,
  input  logic [31:0]              sub_address,
  input  logic [LEN_W-1:0]         sub_len,
  input  logic                     rx_valid,
  input  logic [7:0]               rx_byte,
  output logic                     tx_valid,
  output logic [7:0]               tx_byte,
  output logic [PHY_AW-1:0]        bus_address,
  output logic                     bus_rd,
  output logic                     bus_wr,
  output logic [7:0]               bus_data_out,
  input  logic [7:0]               bus_data_in,
  output logic                     sub_done,
  output logic [1:0]               wkc_inc,
  output logic                     busy
);

  fmmu_state_t      state;
  logic [7:0]       cmd;
  logic [31:0]      addr;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] k;
  logic             rd_hit;
  logic             wr_hit;

  logic [31:0]       laddr;
  logic [N_FMMU-1:0] ch_hit;
  logic [N_FMMU-1:0] ch_rd;
  logic [N_FMMU-1:0] ch_wr;
  logic [PHY_AW-1:0] ch_phy [N_FMMU];

  logic              win_vld;
  logic              win_rd;
  logic              win_wr;
  logic [PHY_AW-1:0] win_phy;
  logic              mapping;
  logic              do_rd;
  logic              do_wr;
  logic [LEN_W:0]    k_nxt;
  logic              last;

  logic       s1_vld;
  logic [7:0] s1_dat;
  logic       s1_sub;

  assign laddr = addr + 32'(k);

  for (genvar i = 0; i < N_FMMU; i++) begin : g_ch
    ethercat_fmmu_match #(
      .PHY_AW(PHY_AW),
      .LEN_W (LEN_W)
    ) u_match (
      .laddr    (laddr),
      .log_start(cfg_log_start[32*i +: 32]),
      .len      (cfg_len[LEN_W*i +: LEN_W]),
      .phy_start(cfg_phy_start[PHY_AW*i +: PHY_AW]),
      .cfg_type (cfg_type[2*i +: 2]),
      .enable   (cfg_enable[i]),
      .hit      (ch_hit[i]),
      .rd_en    (ch_rd[i]),
      .wr_en    (ch_wr[i]),
      .phy_addr (ch_phy[i])
    );
  end

  // Scan high to low so the lowest-index hit is the last one assigned.
  always_comb begin
    win_vld = 1'b0;
    win_rd  = 1'b0;
    win_wr  = 1'b0;
    win_phy = '0;
    for (int i = N_FMMU - 1; i >= 0; i--) begin
      if (ch_hit[i]) begin
        win_vld = 1'b1;
        win_rd  = ch_rd[i];
        win_wr  = ch_wr[i];
        win_phy = ch_phy[i];
      end
    end
  end

  assign mapping = (state == ST_MAP) && rx_valid && !sub_start;
  assign do_rd   = mapping && win_vld && win_rd && ((cmd == CMD_LRD) || (cmd == CMD_LRW));
  assign do_wr   = mapping && win_vld && win_wr && ((cmd == CMD_LWR) || (cmd == CMD_LRW));
  assign k_nxt   = {1'b0, k} + 1'b1;
  assign last    = (k_nxt == {1'b0, len});

  always_ff @(posedge rxc or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      cmd      <= '0;
      addr     <= '0;
      len      <= '0;
      k        <= '0;
      rd_hit   <= 1'b0;
      wr_hit   <= 1'b0;
      sub_done <= 1'b0;
      wkc_inc  <= '0;
    end else begin
      // DONE lasts one cycle; the pulse lands with the last byte's tx_valid.
      sub_done <= (state == ST_DONE);
      wkc_inc  <= (state == ST_DONE) ? wkc_calc(cmd, rd_hit, wr_hit) : 2'b00;
      if (sub_start) begin
        cmd    <= sub_command;
        addr   <= sub_address;
        len    <= sub_len;
        k      <= '0;
        rd_hit <= 1'b0;
        wr_hit <= 1'b0;
        if (sub_len == '0) begin
          state <= ST_DONE;
          busy  <= 1'b0;
        end else if (is_logical(sub_command)) begin
          state <= ST_MAP;
          busy  <= 1'b1;
        end else begin
          state <= ST_PASS;
          busy  <= 1'b1;
        end
      end else begin
        case (state)
          ST_MAP, ST_PASS: begin
            if (rx_valid) begin
              k <= k + 1'b1;
              if (do_rd) rd_hit <= 1'b1;
              if (do_wr) wr_hit <= 1'b1;
              if (last) begin
                state <= ST_DONE;
                busy  <= 1'b0;
              end
            end
          end
          ST_DONE: state <= ST_IDLE;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge rxc or negedge rst_n) begin
    if (!rst_n) begin
      bus_address  <= '0;
      bus_rd       <= 1'b0;
      bus_wr       <= 1'b0;
      bus_data_out <= '0;
      s1_vld       <= 1'b0;
      s1_dat       <= '0;
      s1_sub       <= 1'b0;
      tx_valid     <= 1'b0;
      tx_byte      <= '0;
    end else begin
      bus_rd <= do_rd;
      bus_wr <= do_wr;
      if (do_rd || do_wr) bus_address <= win_phy;
      if (do_wr) bus_data_out <= rx_byte;
      s1_vld   <= rx_valid;
      s1_dat   <= rx_byte;
      s1_sub   <= do_rd;
      tx_valid <= s1_vld;
      // Read data is taken before any same-cycle write lands, giving the pre-write value.
      if (s1_vld) tx_byte <= s1_sub ? bus_data_in : s1_dat;
    end
  end

endmodule

// File: tb/tb_ethercat_fmmu_multi.sv
// Directed bench for ethercat_fmmu_multi with a byte-wide memory on the physical bus.
module tb_ethercat_fmmu_multi;

  localparam int N = 3;

  logic            rxc = 1'b0;
  logic            rst_n = 1'b0;
  logic [N*32-1:0] cfg_log_start = '0;
  logic [N*16-1:0] cfg_len = '0;
  logic [N*16-1:0] cfg_phy_start = '0;
  logic [N*2-1:0]  cfg_type = '0;
  logic [N-1:0]    cfg_enable = '0;
  logic            sub_start = 1'b0;
  logic [7:0]      sub_command = '0;
  logic [31:0]     sub_address = '0;
  logic [15:0]     sub_len = '0;
  logic            rx_valid = 1'b0;
  logic [7:0]      rx_byte = '0;
  logic            tx_valid;
  logic [7:0]      tx_byte;
  logic [15:0]     bus_address;
  logic            bus_rd;
  logic            bus_wr;
  logic [7:0]      bus_data_out;
  logic [7:0]      bus_data_in;
  logic            sub_done;
  logic [1:0]      wkc_inc;
  logic            busy;

  ethercat_fmmu_multi #(.N_FMMU(N), .PHY_AW(16), .LEN_W(16)) dut (
    .rxc(rxc), .rst_n(rst_n),
    .cfg_log_start(cfg_log_start), .cfg_len(cfg_len), .cfg_phy_start(cfg_phy_start),
    .cfg_type(cfg_type), .cfg_enable(cfg_enable),
    .sub_start(sub_start), .sub_command(sub_command), .sub_address(sub_address),
    .sub_len(sub_len), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .tx_valid(tx_valid), .tx_byte(tx_byte), .bus_address(bus_address),
    .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_data_out(bus_data_out),
    .bus_data_in(bus_data_in), .sub_done(sub_done), .wkc_inc(wkc_inc), .busy(busy)
  );

  always #5 rxc = ~rxc;

  // Memory initial contents: mem[a] = a[7:0] + 0x40.
  logic [7:0] mem [0:65535];
  assign bus_data_in = mem[bus_address];
  always @(posedge rxc) if (bus_wr) mem[bus_address] <= bus_data_out;

  logic [7:0]  txq[$];
  logic [25:0] evq[$];
  int          done_cnt = 0;
  int          done_idx = 0;
  logic [1:0]  last_wkc = '0;
  int          cyc = 0;
  int          rx_cyc = -1;
  int          tx_cyc = -1;
  int          passed = 0;
  int          failed = 0;
  int          total = 0;
  int          p;

  always @(posedge rxc) cyc <= cyc + 1;

  always @(negedge rxc) begin
    if (rx_valid && rx_cyc < 0) rx_cyc = cyc;
    if (tx_valid) begin
      txq.push_back(tx_byte);
      if (tx_cyc < 0) tx_cyc = cyc;
    end
    if (bus_rd || bus_wr) evq.push_back({bus_rd, bus_wr, bus_address, bus_data_out});
    if (sub_done) begin
      done_cnt++;
      done_idx = txq.size();
      last_wkc = wkc_inc;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int i, input logic [31:0] s, input logic [15:0] l,
                        input logic [15:0] ph, input logic [1:0] t, input logic en);
    cfg_log_start[32*i +: 32] = s;
    cfg_len[16*i +: 16]       = l;
    cfg_phy_start[16*i +: 16] = ph;
    cfg_type[2*i +: 2]        = t;
    cfg_enable[i]             = en;
  endtask

  task automatic start_dg(input logic [7:0] c, input logic [31:0] a, input logic [15:0] l);
    sub_start   = 1'b1;
    sub_command = c;
    sub_address = a;
    sub_len     = l;
    @(posedge rxc);
    #1 sub_start = 1'b0;
  endtask

  task automatic send(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      rx_valid = 1'b1;
      rx_byte  = base + 8'(i);
      @(posedge rxc);
      #1;
    end
    rx_valid = 1'b0;
  endtask

  task automatic wait_done(input int prev, input string tag);
    for (int n = 0; n < 20 && done_cnt == prev; n++) @(posedge rxc);
    #1;
    chk(tag, done_cnt, prev + 1);
    repeat (2) @(posedge rxc);
    #1;
  endtask

  task automatic clear_q();
    txq.delete();
    evq.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'(a) + 8'h40;
    repeat (3) @(posedge rxc);
    #1;
    chk("reset outputs", {tx_valid, tx_byte, bus_address, bus_rd, bus_wr, bus_data_out,
                          sub_done, wkc_inc, busy}, 39'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge rxc);
    #1;
    chk("post-reset idle", {busy, tx_valid, sub_done}, 3'b000);

    // 1: LRD straddling the start of a 4-byte read window
    set_ch(0, 32'h0001_0000, 16'd4, 16'h1000, 2'b01, 1'b1);
    clear_q(); rx_cyc = -1; tx_cyc = -1; p = done_cnt;
    start_dg(8'h0A, 32'h0000_FFFE, 16'd8);
    chk("t1 busy", busy, 1);
    send(8, 8'h10);
    wait_done(p, "t1 done");
    chk("t1 idle", busy, 0);
    chk("t1 tx count", txq.size(), 8);
    chk("t1 tx0", txq[0], 8'h10);
    chk("t1 tx2", txq[2], 8'h40);
    chk("t1 tx5", txq[5], 8'h43);
    chk("t1 tx6", txq[6], 8'h16);
    chk("t1 rd count", evq.size(), 4);
    for (int i = 0; i < 4; i++) chk("t1 rd addr", evq[i][25:8], {2'b10, 16'(16'h1000 + i)});
    chk("t1 wkc", last_wkc, 2'd1);
    chk("t1 latency", tx_cyc - rx_cyc, 2);
    chk("t1 done with last tx", done_idx, 8);

    // 2: LWR fully inside channel 1's write window
    set_ch(1, 32'h0000_2000, 16'd16, 16'h0200, 2'b10, 1'b1);
    clear_q(); p = done_cnt;
    start_dg(8'h0B, 32'h0000_2004, 16'd4);
    send(4, 8'hA0);
    wait_done(p, "t2 done");
    chk("t2 tx0", txq[0], 8'hA0);
    chk("t2 tx3", txq[3], 8'hA3);
    chk("t2 wr count", evq.size(), 4);
    for (int i = 0; i < 4; i++) chk("t2 wr", evq[i], {2'b01, 16'(16'h0204 + i), 8'(8'hA0 + i)});
    chk("t2 mem", mem[16'h0205], 8'hA1);
    chk("t2 wkc", last_wkc, 2'd1);

    // 3: LRW split across a read channel and a write channel
    set_ch(0, 32'h0000_3000, 16'd2, 16'h0300, 2'b01, 1'b1);
    set_ch(1, 32'h0000_3002, 16'd2, 16'h0400, 2'b10, 1'b1);
    clear_q(); p = done_cnt;
    start_dg(8'h0C, 32'h0000_3000, 16'd4);
    send(4, 8'hB0);
    wait_done(p, "t3 done");
    chk("t3 tx0", txq[0], 8'h40);
    chk("t3 tx1", txq[1], 8'h41);
    chk("t3 tx2", txq[2], 8'hB2);
    chk("t3 tx3", txq[3], 8'hB3);
    chk("t3 ev0", evq[0][25:8], {2'b10, 16'h0300});
    chk("t3 ev3", evq[3], {2'b01, 16'h0401, 8'hB3});
    chk("t3 wkc", last_wkc, 2'd3);

    // 3b: one channel with read and write: old data out, new data written same cycle
    set_ch(0, 32'h0000_3000, 16'd4, 16'h0500, 2'b11, 1'b1);
    cfg_enable[1] = 1'b0;
    clear_q(); p = done_cnt;
    start_dg(8'h0C, 32'h0000_3000, 16'd2);
    send(2, 8'hC0);
    wait_done(p, "t3b done");
    chk("t3b tx0", txq[0], 8'h40);
    chk("t3b tx1", txq[1], 8'h41);
    chk("t3b ev0", evq[0], {2'b11, 16'h0500, 8'hC0});
    chk("t3b ev1", evq[1], {2'b11, 16'h0501, 8'hC1});
    chk("t3b wkc", last_wkc, 2'd3);
    clear_q(); p = done_cnt;
    start_dg(8'h0A, 32'h0000_3000, 16'd2);
    send(2, 8'h00);
    wait_done(p, "t3c done");
    chk("t3c readback0", txq[0], 8'hC0);
    chk("t3c readback1", txq[1], 8'hC1);
    chk("t3c wkc", last_wkc, 2'd1);

    // 4: overlapping channels 0 and 2; then channel 0 disabled
    set_ch(0, 32'h0000_4000, 16'd4, 16'h0600, 2'b01, 1'b1);
    set_ch(2, 32'h0000_4000, 16'd4, 16'h0700, 2'b01, 1'b1);
    clear_q(); p = done_cnt;
    start_dg(8'h0A, 32'h0000_4001, 16'd2);
    send(2, 8'h00);
    wait_done(p, "t4 done");
    chk("t4 ev0", evq[0][25:8], {2'b10, 16'h0601});
    chk("t4 ev1", evq[1][25:8], {2'b10, 16'h0602});
    chk("t4 tx1", txq[1], 8'h42);
    cfg_enable[0] = 1'b0;
    clear_q(); p = done_cnt;
    start_dg(8'h0A, 32'h0000_4001, 16'd2);
    send(2, 8'h00);
    wait_done(p, "t4b done");
    chk("t4b ev0", evq[0][25:8], {2'b10, 16'h0701});
    chk("t4b tx0", txq[0], 8'h41);

    // 5: non-logical command, logical address wrap, zero length
    clear_q(); p = done_cnt;
    start_dg(8'h04, 32'h0000_4000, 16'd3);
    send(3, 8'hD0);
    wait_done(p, "t5 done");
    chk("t5 no strobes", evq.size(), 0);
    chk("t5 tx count", txq.size(), 3);
    chk("t5 tx1", txq[1], 8'hD1);
    chk("t5 wkc", last_wkc, 2'd0);
    set_ch(0, 32'h0000_0000, 16'd2, 16'h0800, 2'b01, 1'b1);
    cfg_enable[2] = 1'b0;
    clear_q(); p = done_cnt;
    start_dg(8'h0A, 32'hFFFF_FFFF, 16'd2);
    send(2, 8'hE0);
    wait_done(p, "t5b done");
    chk("t5b tx0", txq[0], 8'hE0);
    chk("t5b tx1", txq[1], 8'h40);
    chk("t5b rd count", evq.size(), 1);
    chk("t5b ev0", evq[0][25:8], {2'b10, 16'h0800});
    chk("t5b wkc", last_wkc, 2'd1);
    clear_q(); p = done_cnt;
    start_dg(8'h0A, 32'h0000_0000, 16'd0);
    wait_done(p, "t5c done");
    chk("t5c wkc", last_wkc, 2'd0);
    chk("t5c no tx", txq.size(), 0);

    // 6: abort by a new sub_start, then reset mid-datagram
    clear_q(); p = done_cnt;
    start_dg(8'h0A, 32'h0000_0000, 16'd3);
    send(2, 8'h60);
    start_dg(8'h0A, 32'h0000_0000, 16'd2);
    send(2, 8'h70);
    wait_done(p, "t6 done");
    repeat (4) @(posedge rxc);
    #1;
    chk("t6 single done", done_cnt, p + 1);
    chk("t6 tx count", txq.size(), 4);
    chk("t6 tx3", txq[3], 8'h41);
    chk("t6 wkc", last_wkc, 2'd1);
    p = done_cnt;
    start_dg(8'h0A, 32'h0000_0000, 16'd4);
    send(2, 8'h80);
    chk("t6 pre-reset", {busy, bus_rd, tx_valid}, 3'b111);
    rst_n = 1'b0;
    #1;
    chk("t6 reset outputs", {tx_valid, tx_byte, bus_address, bus_rd, bus_wr, bus_data_out,
                             sub_done, wkc_inc, busy}, 39'd0);
    @(posedge rxc);
    #1 rst_n = 1'b1;
    repeat (6) @(posedge rxc);
    #1;
    chk("t6 no done after reset", done_cnt, p);
    chk("t6 idle after reset", {busy, tx_valid}, 2'b00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ethercat_fmmu_multi.md
# ethercat_fmmu_multi

Multi-channel, byte-streaming EtherCAT FMMU. It sits between the datagram receive path and the slave's process-data memory / sync-manager bus. For each payload byte of a logical datagram (LRD/LWR/LRW), it finds the first enabled FMMU channel whose logical window covers the byte address. It then issues a read and/or write on the physical bus, substitutes read data into the forwarded stream, and reports the working-counter increment at datagram end.

## Interface
- `N_FMMU`, 3, number of FMMU channels (1..16)
- `PHY_AW`, 16, physical bus address width
- `LEN_W`, 16, datagram/window length width

- `rxc`  in  1  clock; all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `cfg_log_start`  in  N_FMMU*32  per-channel logical start (channel i at bits [32i+31:32i])
- `cfg_len`  in  N_FMMU*LEN_W  per-channel window length in bytes
- `cfg_phy_start`  in  N_FMMU*PHY_AW  per-channel physical start
- `cfg_type`  in  N_FMMU*2  per-channel bit0 = read enable, bit1 = write enable
- `cfg_enable`  in  N_FMMU  per-channel enable
- `sub_start`  in  1  one-cycle pulse; header fields are valid this cycle
- `sub_command`  in  8  datagram command
- `sub_address`  in  32  logical start address
- `sub_len`  in  LEN_W  payload byte count
- `rx_valid`, `rx_byte`  in  1, 8  payload byte stream
- `tx_valid`, `tx_byte`  out  1, 8  forwarded (possibly substituted) stream
- `bus_address`  out  PHY_AW  physical address
- `bus_rd`, `bus_wr`  out  1, 1  access strobes; both may be high in the same cycle
- `bus_data_out`  out  8  write data
- `bus_data_in`  in  8  read data, combinational from `bus_address` in the `bus_rd` cycle
- `sub_done`  out  1  one-cycle pulse at datagram end
- `wkc_inc`  out  2  WKC increment; valid with `sub_done`, else 0
- `busy`  out  1  high in MAP or PASS

## Operation
- **States:** IDLE, MAP, PASS, DONE.
- **IDLE, `sub_start`:** latch command, address and length; clear byte counter `k`, `rd_hit` and `wr_hit`.
  - Command is LRD (0x0A), LWR (0x0B) or LRW (0x0C) → MAP.
  - Any other command → PASS.
  - `sub_len`=0 → DONE directly.
- **MAP, per accepted byte (`rx_valid`):** `L = sub_address + k`, mod 2^32.
  - Channel i hits when `cfg_enable[i]` is set and `start_i <= L < start_i + len_i`, compared in 33-bit arithmetic (no window wrap).
  - `len_i`=0 never hits. The lowest-index hit wins.
  - Physical address = `phy_start_i + (L - start_i)`, truncated to PHY_AW.
- **Read:** winner type bit0 set and command LRD or LRW → `bus_rd`; byte replaced by `bus_data_in`; set `rd_hit`.
- **Write:** winner type bit1 set and command LWR or LRW → `bus_wr`, `bus_data_out = rx_byte`; set `wr_hit`.
- **LRW with both bits set:** `bus_rd` and `bus_wr` assert in the same cycle. The returned data is the pre-write value (memory is read-before-write).
- **No hit, or hit with the operation not enabled:** byte forwarded unchanged, no bus strobe.
- **PASS:** bytes forwarded unchanged, no bus access, counter still runs.
- **End of datagram:** when `k` reaches `sub_len` → DONE for one cycle.
  - `sub_done`=1.
  - `wkc_inc`: LRD = `rd_hit`; LWR = `wr_hit`; LRW = `rd_hit` + 2·`wr_hit`; others 0.
  - Then → IDLE.
- **Outside MAP/PASS:** `rx_valid` bytes are forwarded unchanged and the counter is frozen.
- **`sub_start` while busy:** current datagram aborted, no `sub_done`, new datagram latched.
- **Config inputs** are evaluated per byte. Software must not change them while `busy`.

## Timing
- **Reset values:** every output 0; state IDLE; counter and hit flags 0.
- **Byte accepted in cycle t:** `bus_address`, `bus_rd`, `bus_wr`, `bus_data_out` registered and valid in t+1; `bus_data_in` sampled at the end of t+1.
- **Forwarded byte:** `tx_valid`/`tx_byte` in t+2. Total latency is 2 cycles for every byte, mapped or not; no bubbles inserted.
- **`sub_done` and `wkc_inc`:** asserted in the same cycle as the `tx_valid` of the last payload byte.
- **Back-to-back:** `sub_start` is accepted in that same cycle, so datagrams can be back-to-back.
- **`rst_n` low mid-datagram:** all pipeline stages and outputs clear immediately; the in-flight datagram produces no `sub_done`.

## Structure
- **Package `ethercat_pkg`:** command codes CMD_LRD/CMD_LWR/CMD_LRW, cfg_type bit positions FMMU_TYPE_RD/FMMU_TYPE_WR, and the state enum.
- **Sub-module `ethercat_fmmu_match`:** one instance per channel via generate. It takes L and one channel's config, and outputs `hit`, `rd_en`, `wr_en` and the physical address.
- **Top level:** priority encoder, FSM, counter, two-stage pipeline.

## Test plan
1. **LRD partial window.** Ch0 start 0x00010000, len 4, phy 0x1000, read. LRD addr 0x0000FFFE, len 8.
   - `bus_rd` at 0x1000–0x1003 for bytes 2–5.
   - tx bytes 2–5 = memory data; other bytes echo rx.
   - `wkc_inc`=1.
2. **LWR.** Ch1 write window covers all 4 bytes.
   - `bus_wr` with rx data at consecutive addresses.
   - tx echoes rx; `wkc_inc`=1.
3. **LRW split.** Ch0 read, ch1 write on adjacent windows, both hit → `wkc_inc`=3.
   - Ch with both bits set: read returns the old value and the write lands in the same cycle.
4. **Overlap priority.** Ch0 and ch2 cover the same range with different phy starts → only ch0's physical addresses appear.
5. **Non-logical command and wrap.** FPRD (0x04), len 3 → no bus strobes, `wkc_inc`=0. LRD at 0xFFFFFFFF, len 2 → L wraps to 0 and hits a window at 0.
6. **Aborts.** `sub_start` mid-datagram → no `sub_done` for the first datagram; the second completes. `rst_n` low mid-datagram → all outputs 0 the next cycle.
